// File: rtl/top_popcount.sv
// Registered population counter: counts the set bits of i_a and captures
// the count on o_q whenever i_load is high; synchronous active-low reset.
module top_popcount #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_load,
  output logic [CW-1:0]    o_q
);

  logic [CW-1:0] w_cnt;
  logic [CW-1:0] r_q;

  // CW must hold WIDTH itself, so the running sum never wraps.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt = w_cnt + CW'(i_a[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= w_cnt;
    end
  end

  assign o_q = r_q;

endmodule

// File: tb/tb_top_popcount.sv
// Directed and random checks for top_popcount; inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_top_popcount;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic       load;
  logic [3:0] q;

  int tests_run;
  int tests_failed;

  top_popcount #(.WIDTH(8), .CW(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_a     (a),
    .i_load  (load),
    .o_q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load  = 1'b1;
    a     = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (q !== 4'd0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: q=%0d expected 0", i, q);
      end
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (q !== 4'd8) begin
      tests_failed++;
      $display("FAIL reset_release: q=%0d expected 8", q);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] vec [4];
    logic [3:0] exp [4];
    vec = '{8'h00, 8'hFF, 8'h80, 8'h01};
    exp = '{4'd0, 4'd8, 4'd1, 4'd1};
    load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = vec[i];
      tick();
      tests_run++;
      if (q !== exp[i]) begin
        tests_failed++;
        $display("FAIL extreme a=%h: q=%0d expected %0d", vec[i], q, exp[i]);
      end
    end
  endtask

  task automatic test_mixed();
    logic [7:0] vec [4];
    logic [3:0] exp [4];
    logic [3:0] prev;
    vec  = '{8'hA5, 8'h7E, 8'h24, 8'hF0};
    exp  = '{4'd4, 4'd6, 4'd2, 4'd4};
    prev = 4'd1;
    load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = vec[i];
      #2;
      tests_run++;
      if (q !== prev) begin
        tests_failed++;
        $display("FAIL latency a=%h: q=%0d before edge, expected %0d", vec[i], q, prev);
      end
      tick();
      tests_run++;
      if (q !== exp[i]) begin
        tests_failed++;
        $display("FAIL mixed a=%h: q=%0d expected %0d", vec[i], q, exp[i]);
      end
      prev = exp[i];
    end
  endtask

  task automatic test_hold();
    load = 1'b1;
    a    = 8'h0F;
    tick();
    tests_run++;
    if (q !== 4'd4) begin
      tests_failed++;
      $display("FAIL hold_load: q=%0d expected 4", q);
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick();
      tests_run++;
      if (q !== 4'd4) begin
        tests_failed++;
        $display("FAIL hold[%0d] a=%h: q=%0d expected 4", i, a, q);
      end
    end
    load = 1'b1;
    a    = 8'h03;
    tick();
    tests_run++;
    if (q !== 4'd2) begin
      tests_failed++;
      $display("FAIL hold_reload: q=%0d expected 2", q);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [3:0] exp;
    load = 1'b1;
    for (int i = 0; i < 12; i++) begin
      v   = 8'($urandom_range(0, 255));
      a   = v;
      exp = 4'($countones(v));
      tick();
      tests_run++;
      if (q !== exp) begin
        tests_failed++;
        $display("FAIL random[%0d] a=%h: q=%0d expected %0d", i, v, q, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    load = 1'b1;
    a    = 8'hFF;
    tick();
    tests_run++;
    if (q !== 4'd8) begin
      tests_failed++;
      $display("FAIL mid_pre: q=%0d expected 8", q);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (q !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: q=%0d expected 0", q);
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (q !== 4'd8) begin
      tests_failed++;
      $display("FAIL mid_release: q=%0d expected 8", q);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [3];
    logic [3:0] exp [3];
    vec  = '{8'h55, 8'hAA, 8'h11};
    exp  = '{4'd4, 4'd4, 4'd2};
    load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = vec[i];
      tick();
      tests_run++;
      if (q !== exp[i]) begin
        tests_failed++;
        $display("FAIL b2b a=%h: q=%0d expected %0d", vec[i], q, exp[i]);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    load  = 1'b0;
    a     = 8'h00;
    #1;
    test_reset();
    test_extremes();
    test_mixed();
    test_hold();
    test_random();
    test_reset_midstream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
